// File: rtl/switch_pkg.sv
// Shared types and helpers for the crossbar output-port arbiters.
package switch_pkg;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

   localparam int DEFAULT_N_PORTS = 4;
   localparam int MAX_PORTS       = 32;
   localparam int MAX_IDX_W       = 5;

   // OR-reduction form: only meaningful for a one-hot (or zero) input.
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_PORTS; i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first requester at or after ptr, wrapping.
module rr_priority_pick
   import switch_pkg::*;
#(
   parameter int N_PORTS = DEFAULT_N_PORTS,
   parameter int IDX_W   = $clog2(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [N_PORTS-1:0] onehot,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [N_PORTS-1:0]   mask;
   logic [2*N_PORTS-1:0] dbl;
   logic [2*N_PORTS-1:0] dbl_oh;

   // Lower half holds requests at/after ptr, upper half the full vector for the wrap.
   always_comb begin
      mask = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      dbl    = {req, req & mask};
      dbl_oh = dbl & ~(dbl - 1'b1);
      onehot = dbl_oh[N_PORTS-1:0] | dbl_oh[2*N_PORTS-1:N_PORTS];
      idx    = IDX_W'(onehot_to_idx(MAX_PORTS'(onehot)));
      any    = |req;
   end

endmodule

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin packet arbiter for one crossbar output port; grants are
// held for a whole packet and a port may take up to its weight in packets back-to-back.
module wrr_packet_arbiter
   import switch_pkg::*;
#(
   parameter  int N_PORTS  = DEFAULT_N_PORTS,
   parameter  int WEIGHT_W = 4,
   localparam int IDX_W    = $clog2(N_PORTS)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_PORTS-1:0]          request_i,
   input  logic                        done_i,
   input  logic [N_PORTS*WEIGHT_W-1:0] weight_i,
   output logic [N_PORTS-1:0]          grant_o,
   output logic                        grant_valid_o,
   output logic [IDX_W-1:0]            grant_idx_o
);

   arb_state_e           state;
   logic [IDX_W-1:0]     ptr;
   logic [WEIGHT_W-1:0]  credit;
   logic [IDX_W-1:0]     pick_ptr;
   logic [N_PORTS-1:0]   pick_oh;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [WEIGHT_W-1:0]  pick_weight;
   logic                 regrant;

   // A zero weight behaves as one packet per turn.
   function automatic logic [WEIGHT_W-1:0] credit_load(input logic [WEIGHT_W-1:0] w);
      return (w == '0) ? '0 : w - 1'b1;
   endfunction

   function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(N_PORTS - 1)) ? '0 : p + 1'b1;
   endfunction

   // When locked, the only re-arbitration that uses the picker is a rotation past cur.
   assign pick_ptr    = (state == ARB_LOCKED) ? inc_ptr(grant_idx_o) : ptr;
   assign pick_weight = weight_i[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
   assign regrant     = (credit != '0) && request_i[grant_idx_o];

   rr_priority_pick #(
      .N_PORTS (N_PORTS),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (request_i),
      .ptr    (pick_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ARB_IDLE;
         ptr           <= '0;
         credit        <= '0;
         grant_o       <= '0;
         grant_valid_o <= 1'b0;
         grant_idx_o   <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  state         <= ARB_LOCKED;
                  grant_o       <= pick_oh;
                  grant_valid_o <= 1'b1;
                  grant_idx_o   <= pick_idx;
                  credit        <= credit_load(pick_weight);
               end
            end
            ARB_LOCKED: begin
               if (done_i) begin
                  if (regrant) begin
                     credit <= credit - 1'b1;
                  end else begin
                     ptr <= inc_ptr(grant_idx_o);
                     if (pick_any) begin
                        grant_o     <= pick_oh;
                        grant_idx_o <= pick_idx;
                        credit      <= credit_load(pick_weight);
                     end else begin
                        state         <= ARB_IDLE;
                        grant_o       <= '0;
                        grant_valid_o <= 1'b0;
                        grant_idx_o   <= '0;
                     end
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Directed scoreboard bench for wrr_packet_arbiter (4 ports, 4-bit weights).
module tb_wrr_packet_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  request_i;
   logic        done_i;
   logic [15:0] weight_i;
   logic [3:0]  grant_o;
   logic        grant_valid_o;
   logic [1:0]  grant_idx_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic [3:0]  exp_q[$];

   wrr_packet_arbiter #(
      .N_PORTS  (4),
      .WEIGHT_W (4)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .request_i     (request_i),
      .done_i        (done_i),
      .weight_i      (weight_i),
      .grant_o       (grant_o),
      .grant_valid_o (grant_valid_o),
      .grant_idx_o   (grant_idx_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   // Drive one cycle of stimulus, queue the grant expected after the edge, then compare.
   task automatic cyc(input string tag, input logic r, input logic [3:0] req,
                      input logic d, input logic [3:0] exp);
      logic [3:0] e;
      rst_i     = r;
      request_i = req;
      done_i    = d;
      exp_q.push_back(exp);
      @(posedge clk_i);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_grant"}, 32'(grant_o), 32'(e));
         chk({tag, "_idx"},   32'(grant_idx_o), 32'(oh2idx(e)));
         chk({tag, "_valid"}, 32'(grant_valid_o), 32'(|e));
      end
   endtask

   always @(negedge clk_i) begin
      if (mon_en) begin
         chk("inv_onehot", 32'($countones(grant_o) <= 1), 32'd1);
         chk("inv_valid",  32'(grant_valid_o), 32'(|grant_o));
         chk("inv_idx",    32'(grant_idx_o), 32'(oh2idx(grant_o)));
      end
   end

   initial begin
      rst_i     = 1'b1;
      request_i = 4'b0000;
      done_i    = 1'b0;
      weight_i  = 16'h1111;
      mon_en    = 1'b1;

      // Reset dominates pending requests
      cyc("rst0", 1'b1, 4'b1111, 1'b0, 4'b0000);
      cyc("rst1", 1'b1, 4'b1111, 1'b0, 4'b0000);

      // Plain round robin, one packet each
      cyc("rr0", 1'b0, 4'b1111, 1'b1, 4'b0001);
      cyc("rr1", 1'b0, 4'b1111, 1'b1, 4'b0010);
      cyc("rr2", 1'b0, 4'b1111, 1'b1, 4'b0100);
      cyc("rr3", 1'b0, 4'b1111, 1'b1, 4'b1000);
      cyc("rr4", 1'b0, 4'b1111, 1'b1, 4'b0001);
      cyc("to_idle",   1'b0, 4'b0000, 1'b1, 4'b0000);
      cyc("idle_done", 1'b0, 4'b0000, 1'b1, 4'b0000);
      cyc("ptr_adv",   1'b0, 4'b0011, 1'b0, 4'b0010);

      // Packet lock: held through request drop until done
      cyc("lrst", 1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc("lock1", 1'b0, 4'b0011, 1'b0, 4'b0001);
      cyc("lock2", 1'b0, 4'b0011, 1'b0, 4'b0001);
      cyc("lock3", 1'b0, 4'b0010, 1'b0, 4'b0001);
      cyc("lock4", 1'b0, 4'b0010, 1'b0, 4'b0001);
      cyc("lock5", 1'b0, 4'b0011, 1'b0, 4'b0001);
      cyc("lock6", 1'b0, 4'b0011, 1'b1, 4'b0010);

      // Weights 3,1,1,1; weight0 changed mid-credit must not matter
      weight_i = 16'h1113;
      cyc("wrst", 1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc("w0", 1'b0, 4'b0011, 1'b1, 4'b0001);
      weight_i = 16'h1111;
      cyc("w1", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("w2", 1'b0, 4'b0011, 1'b1, 4'b0001);
      weight_i = 16'h1113;
      cyc("w3", 1'b0, 4'b0011, 1'b1, 4'b0010);
      cyc("w4", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("w5", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("w6", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("w7", 1'b0, 4'b0011, 1'b1, 4'b0010);

      // Credit forfeit and reload
      cyc("frst", 1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc("f0", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("f1", 1'b0, 4'b0010, 1'b1, 4'b0010);
      cyc("f2", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("f3", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("f4", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("f5", 1'b0, 4'b0011, 1'b1, 4'b0010);

      // Zero weights act as one
      weight_i = 16'h0000;
      cyc("zrst", 1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc("z0", 1'b0, 4'b0011, 1'b1, 4'b0001);
      cyc("z1", 1'b0, 4'b0011, 1'b1, 4'b0010);
      cyc("z2", 1'b0, 4'b0011, 1'b1, 4'b0001);

      // Reset in the middle of a locked packet
      weight_i = 16'h1111;
      cyc("mrst", 1'b1, 4'b0000, 1'b0, 4'b0000);
      cyc("m1", 1'b0, 4'b0100, 1'b0, 4'b0100);
      cyc("m2", 1'b0, 4'b0100, 1'b0, 4'b0100);
      cyc("m3", 1'b0, 4'b0100, 1'b0, 4'b0100);
      cyc("m_rst", 1'b1, 4'b0100, 1'b0, 4'b0000);
      cyc("m_after", 1'b0, 4'b0101, 1'b0, 4'b0001);

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
